// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes, read return and memory command signals for mem_port_arbiter.
// The arbiter connects through the slave modport; requesters and memory use master.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;

  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_gnt;
  logic          dbg_rvalid;

  logic [DW-1:0] rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dbg_req, dbg_addr, mem_rdata,
    output if_gnt, if_rvalid, dm_gnt, dm_rvalid, dbg_gnt, dbg_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dbg_req, dbg_addr, mem_rdata,
    input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, dbg_gnt, dbg_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (dm > if > dbg) arbiter for a single-port synchronous memory, with
// starvation promotion for fetch and debug and one-cycle read data steering.
module mem_port_arbiter #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned WW = 8;
  localparam logic [WW-1:0] WAIT_SAT = WW'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [WW-1:0] wait_if, wait_if_d;
  logic [WW-1:0] wait_dbg, wait_dbg_d;
  logic          gnt_if, gnt_dm, gnt_dbg;
  logic          sat_if, sat_dbg;
  logic          any_rvalid;

  assign sat_if  = (wait_if == WAIT_SAT);
  assign sat_dbg = (wait_dbg == WAIT_SAT);

  // Owner of the read in flight and the starvation counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      wait_if  <= '0;
      wait_dbg <= '0;
    end else begin
      owner_q  <= owner_d;
      wait_if  <= wait_if_d;
      wait_dbg <= wait_dbg_d;
    end
  end

  // Grant selection, next owner and counter updates; grants are held off during reset.
  always_comb begin
    gnt_if     = 1'b0;
    gnt_dm     = 1'b0;
    gnt_dbg    = 1'b0;
    owner_d    = OWN_NONE;
    wait_if_d  = '0;
    wait_dbg_d = '0;

    if (rst_n) begin
      if (bus.if_req && sat_if)        gnt_if  = 1'b1;
      else if (bus.dbg_req && sat_dbg) gnt_dbg = 1'b1;
      else if (bus.dm_req)             gnt_dm  = 1'b1;
      else if (bus.if_req)             gnt_if  = 1'b1;
      else if (bus.dbg_req)            gnt_dbg = 1'b1;
    end

    if (gnt_if)                     owner_d = OWN_IF;
    else if (gnt_dbg)               owner_d = OWN_DBG;
    else if (gnt_dm && !bus.dm_we)  owner_d = OWN_DM;

    if (bus.if_req && !gnt_if)
      wait_if_d = sat_if ? wait_if : WW'(wait_if + WW'(1));
    if (bus.dbg_req && !gnt_dbg)
      wait_dbg_d = sat_dbg ? wait_dbg : WW'(wait_dbg + WW'(1));
  end

  // Memory command mux; address and write data read as zero when unused.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_dm) begin
      bus.mem_addr = bus.dm_addr;
      if (bus.dm_we) bus.mem_wdata = bus.dm_wdata;
    end else if (gnt_if) begin
      bus.mem_addr = bus.if_addr;
    end else if (gnt_dbg) begin
      bus.mem_addr = bus.dbg_addr;
    end
  end

  assign bus.if_gnt  = gnt_if;
  assign bus.dm_gnt  = gnt_dm;
  assign bus.dbg_gnt = gnt_dbg;
  assign bus.mem_en  = gnt_if | gnt_dm | gnt_dbg;
  assign bus.mem_we  = gnt_dm & bus.dm_we;

  assign bus.if_rvalid  = (owner_q == OWN_IF);
  assign bus.dm_rvalid  = (owner_q == OWN_DM);
  assign bus.dbg_rvalid = (owner_q == OWN_DBG);
  assign any_rvalid     = (owner_q != OWN_NONE);
  assign bus.rdata      = any_rvalid ? bus.mem_rdata : '0;

endmodule
